minhash_bottomk_sorter: RTL and testbench

- Sits between the hasher and the extender.
- Consumes one signature_index_pack per k-mer of a fragment and keeps the SORTER_EXTENDER_INDICES_COUNT smallest signatures (bottom-k minhash) in a registered insertion-sorted list.
- At end of fragment it presents the sorted indices to the extender and holds them until the extender accepts.
- Uses proj_pkg types and parameters.

---
 rtl/minhash_bottomk_sorter.sv | 147 ++++++++++++++
 tb/tb_minhash_bottomk_sorter.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/minhash_bottomk_sorter.sv
// Bottom-k minhash sorter: keeps the K smallest signatures of a fragment in a
// registered, stably insertion-sorted list and hands them to the extender.
//
// state   | meaning
// COLLECT | accepting packs, one parallel insertion per accepted pack
// DRAIN   | sorted result presented (out_valid=1), waiting for out_ready
module minhash_bottomk_sorter #(
  parameter int K     = 4,
  parameter int SIG_W = 32,
  parameter int IDX_W = 5,
  parameter int CNT_W = $clog2(K + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [SIG_W+IDX_W-1:0] in_pack,
  input  logic                 in_last,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [K*IDX_W-1:0]   out_indices,
  output logic [K*SIG_W-1:0]   out_signatures,
  output logic [CNT_W-1:0]     out_count
);

  localparam logic [0:0] COLLECT = 1'b0;
  localparam logic [0:0] DRAIN   = 1'b1;

  logic [0:0]       state;
  logic [SIG_W-1:0] slot_sig [K];
  logic [IDX_W-1:0] slot_idx [K];
  logic [K-1:0]     slot_vld;

  logic [SIG_W-1:0] in_sig;
  logic [IDX_W-1:0] in_idx;
  logic             accept;
  logic             handshake;

  logic [K-1:0]     le;
  logic [K:0]       le_ext;
  logic [SIG_W-1:0] prev_sig [K];
  logic [IDX_W-1:0] prev_idx [K];
  logic [K-1:0]     prev_vld;
  logic [SIG_W-1:0] nxt_sig  [K];
  logic [IDX_W-1:0] nxt_idx  [K];
  logic [K-1:0]     nxt_vld;
  logic [CNT_W-1:0] cnt;

  assign {in_sig, in_idx} = in_pack;
  assign accept    = in_valid & in_ready;
  assign out_valid = (state == DRAIN);
  assign handshake = out_valid & out_ready;

  // Valid slots are sorted ascending, so le is a prefix: p = first slot with le=0.
  // Using <= keeps earlier-arriving equal signatures ahead of the new one.
  always_comb begin
    le        = '0;
    le_ext    = '0;
    le_ext[0] = 1'b1;
    prev_vld  = '0;
    for (int i = 0; i < K; i++) begin
      le[i]       = slot_vld[i] && (slot_sig[i] <= in_sig);
      le_ext[i+1] = le[i];
      prev_sig[i] = '1;
      prev_idx[i] = '0;
    end
    for (int i = 1; i < K; i++) begin
      prev_sig[i] = slot_sig[i-1];
      prev_idx[i] = slot_idx[i-1];
      prev_vld[i] = slot_vld[i-1];
    end
  end

  always_comb begin
    nxt_vld = slot_vld;
    for (int i = 0; i < K; i++) begin
      nxt_sig[i] = slot_sig[i];
      nxt_idx[i] = slot_idx[i];
      if (!le[i]) begin
        if (le_ext[i]) begin
          nxt_sig[i] = in_sig;
          nxt_idx[i] = in_idx;
          nxt_vld[i] = 1'b1;
        end else begin
          nxt_sig[i] = prev_sig[i];
          nxt_idx[i] = prev_idx[i];
          nxt_vld[i] = prev_vld[i];
        end
      end
    end
  end

  always_comb begin
    cnt = '0;
    for (int i = 0; i < K; i++) cnt = cnt + CNT_W'(slot_vld[i]);
    if (cnt > CNT_W'(K)) cnt = CNT_W'(K);
  end

  always_comb begin
    out_indices    = '0;
    out_signatures = '0;
    for (int i = 0; i < K; i++) begin
      out_indices[i*IDX_W +: IDX_W]    = slot_idx[i];
      out_signatures[i*SIG_W +: SIG_W] = slot_sig[i];
    end
  end

  assign out_count = cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= COLLECT;
      in_ready <= 1'b0;
      slot_vld <= '0;
      for (int i = 0; i < K; i++) begin
        slot_sig[i] <= '1;
        slot_idx[i] <= '0;
      end
    end else begin
      case (state)
        COLLECT: begin
          in_ready <= !(accept && in_last);
          if (accept) begin
            slot_vld <= nxt_vld;
            for (int i = 0; i < K; i++) begin
              slot_sig[i] <= nxt_sig[i];
              slot_idx[i] <= nxt_idx[i];
            end
            if (in_last) state <= DRAIN;
          end
        end
        default: begin
          in_ready <= handshake;
          if (handshake) begin
            state    <= COLLECT;
            slot_vld <= '0;
            for (int i = 0; i < K; i++) begin
              slot_sig[i] <= '1;
              slot_idx[i] <= '0;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_minhash_bottomk_sorter.sv
// Directed and randomized checks of the bottom-k sorter against hand-derived
// results and a selection-sort reference.
module tb_minhash_bottomk_sorter;
  localparam int K = 4;
  localparam int SIG_W = 32;
  localparam int IDX_W = 5;
  localparam int CNT_W = 3;

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic                   in_valid;
  logic                   in_ready;
  logic [SIG_W+IDX_W-1:0] in_pack;
  logic                   in_last;
  logic                   out_valid;
  logic                   out_ready;
  logic [K*IDX_W-1:0]     out_indices;
  logic [K*SIG_W-1:0]     out_signatures;
  logic [CNT_W-1:0]       out_count;

  int checks = 0;
  int errors = 0;

  localparam logic [31:0] ONES = 32'hFFFF_FFFF;

  minhash_bottomk_sorter #(.K(K), .SIG_W(SIG_W), .IDX_W(IDX_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_pack(in_pack), .in_last(in_last), .out_valid(out_valid),
    .out_ready(out_ready), .out_indices(out_indices),
    .out_signatures(out_signatures), .out_count(out_count)
  );

  always #5 clk = ~clk;

  // Present one pack until accepted; returns #1 after the accepting edge.
  task automatic push(input logic [31:0] s, input logic [4:0] ix, input logic last);
    logic acc;
    logic ok;
    in_valid = 1'b1;
    in_pack  = {s, ix};
    in_last  = last;
    ok = 1'b0;
    for (int t = 0; t < 100; t++) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      if (acc) begin
        ok = 1'b1;
        break;
      end
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    if (!ok) begin
      errors++;
      $display("FAIL push_timeout sig=%0d idx=%0d not accepted in 100 cycles", s, ix);
    end
  endtask

  task automatic drain();
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL drain_out_valid got %b want 0", out_valid);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; in_pack = '0; in_last = 1'b0; out_ready = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0 || out_count !== 3'd0 ||
        out_signatures !== {K{ONES}} || out_indices !== '0) begin
      errors++;
      $display("FAIL reset_state in_ready=%b out_valid=%b count=%0d sigs=%h idx=%h",
               in_ready, out_valid, out_count, out_signatures, out_indices);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release_in_ready got %b want 1", in_ready);
    end
  endtask

  task automatic test_basic();
    out_ready = 1'b1;
    push(32'd40, 5'd0, 1'b0);
    push(32'd10, 5'd1, 1'b0);
    push(32'd30, 5'd2, 1'b0);
    push(32'd20, 5'd3, 1'b0);
    push(32'd50, 5'd4, 1'b1);
    checks++;
    if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL basic_latency out_valid=%b in_ready=%b want 1/0", out_valid, in_ready);
    end
    checks++;
    if (out_indices !== {5'd0, 5'd2, 5'd3, 5'd1} ||
        out_signatures !== {32'd40, 32'd30, 32'd20, 32'd10} || out_count !== 3'd4) begin
      errors++;
      $display("FAIL basic_result idx=%h sigs=%h count=%0d", out_indices, out_signatures, out_count);
    end
    @(posedge clk); #1;
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL basic_refill out_valid=%b in_ready=%b want 0/1", out_valid, in_ready);
    end
  endtask

  task automatic test_ties();
    push(32'd7, 5'd5, 1'b0);
    push(32'd7, 5'd6, 1'b0);
    push(32'd3, 5'd7, 1'b1);
    checks++;
    if (out_valid !== 1'b1 || out_indices !== {5'd0, 5'd6, 5'd5, 5'd7} ||
        out_signatures !== {ONES, 32'd7, 32'd7, 32'd3} || out_count !== 3'd3) begin
      errors++;
      $display("FAIL ties_result valid=%b idx=%h sigs=%h count=%0d",
               out_valid, out_indices, out_signatures, out_count);
    end
    drain();
  endtask

  task automatic test_single();
    push(32'hFFFF_FFFE, 5'd9, 1'b1);
    checks++;
    if (out_valid !== 1'b1 || out_count !== 3'd1 || out_indices !== {5'd0, 5'd0, 5'd0, 5'd9} ||
        out_signatures !== {ONES, ONES, ONES, 32'hFFFF_FFFE}) begin
      errors++;
      $display("FAIL single_result valid=%b idx=%h sigs=%h count=%0d",
               out_valid, out_indices, out_signatures, out_count);
    end
    drain();
  endtask

  task automatic test_hold();
    push(32'd5, 5'd3, 1'b0);
    push(32'd6, 5'd4, 1'b1);
    in_valid = 1'b1;
    in_pack  = {32'd1, 5'd9};
    in_last  = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_count !== 3'd2 ||
          out_indices !== {5'd0, 5'd0, 5'd4, 5'd3} ||
          out_signatures !== {ONES, ONES, 32'd6, 32'd5}) begin
        errors++;
        $display("FAIL hold_cycle%0d valid=%b in_ready=%b idx=%h sigs=%h count=%0d",
                 c, out_valid, in_ready, out_indices, out_signatures, out_count);
      end
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    drain();
    push(32'd100, 5'd1, 1'b1);
    checks++;
    if (out_count !== 3'd1 || out_indices !== {5'd0, 5'd0, 5'd0, 5'd1} ||
        out_signatures !== {ONES, ONES, ONES, 32'd100}) begin
      errors++;
      $display("FAIL hold_after_empty idx=%h sigs=%h count=%0d",
               out_indices, out_signatures, out_count);
    end
    drain();
  endtask

  task automatic test_reset_mid();
    push(32'd0, 5'd20, 1'b0);
    push(32'd0, 5'd21, 1'b0);
    push(32'd0, 5'd22, 1'b0);
    rst_n = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (out_count !== 3'd0 || out_signatures !== {K{ONES}} || out_indices !== '0 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL midreset_clear count=%0d sigs=%h idx=%h in_ready=%b",
               out_count, out_signatures, out_indices, in_ready);
    end
    rst_n = 1'b1;
    push(32'd2, 5'd0, 1'b0);
    push(32'd1, 5'd1, 1'b1);
    checks++;
    if (out_count !== 3'd2 || out_indices !== {5'd0, 5'd0, 5'd0, 5'd1} ||
        out_signatures !== {ONES, ONES, 32'd2, 32'd1}) begin
      errors++;
      $display("FAIL midreset_result idx=%h sigs=%h count=%0d",
               out_indices, out_signatures, out_count);
    end
    drain();
  endtask

  task automatic test_random();
    logic [31:0]        sig_a [12];
    logic [4:0]         idx_a [12];
    logic [11:0]        taken;
    logic [K*IDX_W-1:0] exp_idx;
    logic [K*SIG_W-1:0] exp_sig;
    logic [CNT_W-1:0]   exp_cnt;
    int n;
    int best;
    for (int f = 0; f < 1000; f++) begin
      n = $urandom_range(1, 12);
      for (int j = 0; j < n; j++) begin
        sig_a[j] = ($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 7)) : $urandom;
        idx_a[j] = 5'($urandom_range(0, 31));
      end
      // Stable selection: smallest first, earliest arrival wins ties.
      exp_cnt = (n < K) ? CNT_W'(n) : CNT_W'(K);
      exp_sig = {K{ONES}};
      exp_idx = '0;
      taken = '0;
      for (int s = 0; s < int'(exp_cnt); s++) begin
        best = -1;
        for (int j = 0; j < n; j++)
          if (!taken[j] && (best < 0 || sig_a[j] < sig_a[best])) best = j;
        taken[best] = 1'b1;
        exp_sig[s*SIG_W +: SIG_W] = sig_a[best];
        exp_idx[s*IDX_W +: IDX_W] = idx_a[best];
      end
      for (int j = 0; j < n; j++) begin
        if ($urandom_range(0, 2) == 0) begin
          in_valid = 1'b0;
          in_pack  = {$urandom, 5'($urandom_range(0, 31))};
          in_last  = 1'($urandom_range(0, 1));
          out_ready = 1'($urandom_range(0, 1));
          repeat ($urandom_range(1, 3)) @(posedge clk);
          #1;
        end
        out_ready = (j == n - 1) ? 1'b0 : 1'($urandom_range(0, 1));
        push(sig_a[j], idx_a[j], (j == n - 1) ? 1'b1 : 1'b0);
      end
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
      checks++;
      if (out_valid !== 1'b1 || out_indices !== exp_idx || out_signatures !== exp_sig ||
          out_count !== exp_cnt) begin
        errors++;
        $display("FAIL random_frag%0d len=%0d valid=%b idx=%h/%h sigs=%h/%h count=%0d/%0d",
                 f, n, out_valid, out_indices, exp_idx, out_signatures, exp_sig, out_count, exp_cnt);
      end
      drain();
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_ties();
    test_single();
    test_hold();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
